// File: rtl/hpf_fir31.sv
// 31-tap high-pass FIR: circular sample history, one MAC per clock against an
// external coefficient ROM addressed by index, saturated output per input sample.
module hpf_fir31 #(
    parameter int TAPS = 31,
    parameter int DW   = 8,
    parameter int CW   = 10,
    parameter int AW   = 24,
    parameter int OW   = 18
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ready,
    input  logic signed [DW-1:0] x,
    output logic [4:0]           index,
    input  logic signed [CW-1:0] coeff,
    output logic signed [OW-1:0] y,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LAST_I = TAPS - 1;
    localparam logic [4:0] LAST_IDX = LAST_I[4:0];
    localparam int YMAX_I = (1 << (OW - 1)) - 1;
    localparam int YMIN_I = -(1 << (OW - 1));
    localparam logic signed [AW-1:0] Y_MAX = YMAX_I[AW-1:0];
    localparam logic signed [AW-1:0] Y_MIN = YMIN_I[AW-1:0];

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic                        accept_s;
    logic                        mac_s;
    logic                        done_s;
    logic [4:0]                  offset_r;
    logic [4:0]                  index_r;
    logic [4:0]                  rd_addr_s;
    logic signed [DW-1:0]        hist_r [32];
    logic signed [DW-1:0]        sample_s;
    logic signed [DW+CW-1:0]     prod_s;
    logic signed [AW-1:0]        prod_ext_s;
    logic signed [AW-1:0]        acc_r;
    logic signed [OW-1:0]        y_r;
    logic                        y_valid_r;
    logic                        busy_r;
    logic                        overrun_r;

    function automatic logic signed [OW-1:0] sat_out(input logic signed [AW-1:0] a);
        logic signed [OW-1:0] r;
        if (a > Y_MAX) begin
            r = Y_MAX[OW-1:0];
        end else if (a < Y_MIN) begin
            r = Y_MIN[OW-1:0];
        end else begin
            r = a[OW-1:0];
        end
        return r;
    endfunction

    // index 0 pairs with the newest sample, which sits one slot behind the write offset
    assign rd_addr_s  = offset_r - 5'd1 - index_r;
    assign sample_s   = hist_r[rd_addr_s];
    assign prod_s     = sample_s * coeff;
    assign prod_ext_s = {{(AW-DW-CW){prod_s[DW+CW-1]}}, prod_s};

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state decode and per-state control strobes
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        mac_s       = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (ready) begin
                    accept_s    = 1'b1;
                    state_nxt_s = MAC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MAC: begin
                mac_s = 1'b1;
                if (index_r == LAST_IDX) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = MAC;
                end
            end
            DONE: begin
                done_s      = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // datapath: history write, accumulate, saturate, status pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                hist_r[i] <= '0;
            end
            offset_r  <= 5'd0;
            index_r   <= 5'd0;
            acc_r     <= '0;
            y_r       <= '0;
            y_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            y_valid_r <= done_s;
            overrun_r <= ready && (state_r != IDLE);
            busy_r    <= (state_nxt_s != IDLE);
            if (accept_s) begin
                hist_r[offset_r] <= x;
                offset_r         <= offset_r + 5'd1;
                acc_r            <= '0;
                index_r          <= 5'd0;
            end else if (mac_s) begin
                acc_r <= acc_r + prod_ext_s;
                if (index_r != LAST_IDX) begin
                    index_r <= index_r + 5'd1;
                end else begin
                    index_r <= index_r;
                end
            end else if (done_s) begin
                y_r     <= sat_out(acc_r);
                index_r <= 5'd0;
            end else begin
                index_r <= 5'd0;
            end
        end
    end

    assign index   = index_r;
    assign y       = y_r;
    assign y_valid = y_valid_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_hpf_fir31.sv
// Directed bench for hpf_fir31 with a symmetric high-pass coefficient ROM model
// (taps 2 at both ends, 923 at centre, DC sum 23).
module tb_hpf_fir31;

    // centre tap 923 needs 11 signed bits, so the ROM here is one bit wider
    localparam int CW = 11;

    logic               clock;
    logic               reset_n;
    logic               ready;
    logic signed [7:0]  x;
    logic [4:0]         index;
    logic signed [CW-1:0] coeff;
    logic signed [17:0] y;
    logic               y_valid;
    logic               busy;
    logic               overrun;

    int rom [0:30] = '{2, 3, 4, 2, -1, -3, -6, -10, -16, -24, -34, -46, -60, -80, -181,
                       923,
                       -181, -80, -60, -46, -34, -24, -16, -10, -6, -3, -1, 2, 4, 3, 2};
    int mh [0:31];
    int checks = 0;
    int failures = 0;
    int rom_val;
    int yv;

    hpf_fir31 #(.CW(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ready   (ready),
        .x       (x),
        .index   (index),
        .coeff   (coeff),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        rom_val = 0;
        if (index < 5'd31) rom_val = rom[index];
        coeff = rom_val[CW-1:0];
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int model_y();
        int s = 0;
        for (int k = 0; k < 31; k++) s += rom[k] * mh[k];
        if (s > 131071) s = 131071;
        if (s < -131072) s = -131072;
        return s;
    endfunction

    task automatic model_push(input int xv);
        for (int k = 31; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = xv;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 32; k++) mh[k] = 0;
    endtask

    task automatic wait_result(output int yo);
        bit got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (y_valid === 1'b1) got = 1'b1;
        end
        check("y_valid_seen", int'(got), 1);
        yo = int'($signed(y));
        check("y_vs_model", yo, model_y());
    endtask

    task automatic send(input int xv, output int yo);
        check("idle_before_send", int'(busy), 0);
        ready = 1'b1;
        x = xv[7:0];
        tick();
        ready = 1'b0;
        x = 8'sd0;
        model_push(xv);
        wait_result(yo);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        model_clear();
        tick();
    endtask

    initial begin
        bit seen;
        bit found;
        ready = 1'b0;
        x = 8'sd0;
        reset_n = 1'b0;
        model_clear();
        tick();
        check("rst_index", int'(index), 0);
        check("rst_y", int'($signed(y)), 0);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        tick();

        // impulse response
        for (int k = 0; k < 32; k++) begin
            send((k == 0) ? 127 : 0, yv);
            if (k == 0) check("imp_first", yv, 254);
            if (k == 15) check("imp_centre", yv, 117221);
            if (k == 30) check("imp_last", yv, 254);
            if (k == 31) check("imp_after", yv, 0);
        end

        // DC step settles to 127*23
        for (int k = 0; k < 32; k++) send(127, yv);
        check("dc_settled", yv, 2921);

        // saturation, both polarities
        for (int j = 0; j < 31; j++) send((rom[j] > 0) ? 127 : -128, yv);
        check("sat_pos", yv, 131071);
        for (int j = 0; j < 31; j++) send((rom[j] > 0) ? -128 : 127, yv);
        check("sat_neg", yv, -131072);

        // overrun: ready 10 clocks after acceptance is dropped
        do_reset();
        ready = 1'b1;
        x = 8'sd127;
        tick();
        ready = 1'b0;
        x = 8'sd0;
        model_push(127);
        repeat (9) tick();
        ready = 1'b1;
        x = 8'sd55;
        tick();
        ready = 1'b0;
        x = 8'sd0;
        check("ovr_pulse", int'(overrun), 1);
        check("ovr_busy", int'(busy), 1);
        tick();
        check("ovr_single", int'(overrun), 0);
        wait_result(yv);
        check("ovr_first", yv, 254);
        for (int k = 1; k < 31; k++) begin
            send(0, yv);
            if (k == 15) check("ovr_centre", yv, 117221);
            if (k == 30) check("ovr_last", yv, 254);
        end

        // reset in the middle of a MAC
        ready = 1'b1;
        x = 8'sd127;
        tick();
        ready = 1'b0;
        x = 8'sd0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (index == 5'd12) found = 1'b1;
            else tick();
        end
        check("mid_index12", int'(found), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_index", int'(index), 0);
        check("mid_rst_busy", int'(busy), 0);
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (y_valid === 1'b1) seen = 1'b1;
        end
        reset_n = 1'b1;
        model_clear();
        for (int n = 0; n < 40; n++) begin
            tick();
            if (y_valid === 1'b1) seen = 1'b1;
        end
        check("mid_no_valid", int'(seen), 0);
        check("mid_index", int'(index), 0);
        check("mid_y", int'($signed(y)), 0);
        check("mid_busy", int'(busy), 0);

        // impulse after reset, then across the offset wrap
        for (int k = 0; k < 40; k++) begin
            send((k == 0) ? 127 : 0, yv);
            if (k == 0) check("wrap_first", yv, 254);
            if (k == 15) check("wrap_centre", yv, 117221);
            if (k == 30) check("wrap_last", yv, 254);
            if (k == 39) check("wrap_tail", yv, 0);
        end
        for (int k = 0; k < 40; k++) begin
            send((k == 0) ? 127 : 0, yv);
            if (k < 31) check("wrap2_tap", yv, 127 * rom[k]);
            else check("wrap2_zero", yv, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
